// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, ALU mode
// encodings, FSM states and an instruction-field extraction helper.
package multicycle_control_unit_pkg;

   localparam int unsigned OP_LOAD = 0;
   localparam int unsigned OP_MOV  = 1;
   localparam int unsigned OP_ADD  = 2;
   localparam int unsigned OP_SUB  = 3;
   localparam int unsigned OP_XOR  = 4;
   localparam int unsigned OP_AND  = 5;
   localparam int unsigned OP_OR   = 6;
   localparam int unsigned OP_NOP  = 7;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_XOR = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b011;
   localparam logic [2:0] ALU_OR  = 3'b100;

   typedef enum logic [3:0] {
      IDLE, LOAD1, LOAD2, MOVE, ALU1, ALU2, ALU3, NOPS, ERR
   } state_t;

   // Returns the width-bit field starting at bit lsb; callers cast to the field width.
   function automatic logic [63:0] instr_field(input logic [63:0] word, input int lsb,
                                               input int width);
      return (word >> lsb) & ((64'd1 << width) - 64'd1);
   endfunction

   function automatic logic [2:0] alu_mode_of(input int unsigned op);
      case (op)
         OP_SUB:  return ALU_SUB;
         OP_XOR:  return ALU_XOR;
         OP_AND:  return ALU_AND;
         OP_OR:   return ALU_OR;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Instruction handshake and datapath strobes between the control unit (slave)
// and the instruction source / register file / ALU side (master).
interface multicycle_control_unit_if #(
   parameter int NUM_REGS  = 16,
   parameter int REG_SEL_W = $clog2(NUM_REGS),
   parameter int OPCODE_W  = 4
);
   logic                              instr_valid;
   logic                              instr_ready;
   logic [OPCODE_W+2*REG_SEL_W-1:0]   instr;
   logic                              ext_data_valid;
   logic [NUM_REGS-1:0]               rin;
   logic [NUM_REGS-1:0]               rout;
   logic [2:0]                        alu_mode;
   logic                              alu_a_in;
   logic                              alu_g_in;
   logic                              alu_g_out;
   logic                              ext_load;

   modport master (
      output instr_valid, instr, ext_data_valid,
      input  instr_ready, rin, rout, alu_mode, alu_a_in, alu_g_in, alu_g_out, ext_load
   );

   modport slave (
      input  instr_valid, instr, ext_data_valid,
      output instr_ready, rin, rout, alu_mode, alu_a_in, alu_g_in, alu_g_out, ext_load
   );
endinterface

// File: rtl/multicycle_control_unit_reg_sel_decoder.sv
// Register-select to one-hot decoder; out_of_range flags selects beyond NUM_REGS
// independently of the enable, and such selects never produce a strobe.
module reg_sel_decoder #(
   parameter int NUM_REGS  = 16,
   parameter int REG_SEL_W = $clog2(NUM_REGS)
) (
   input  logic [REG_SEL_W-1:0] sel,
   input  logic                 en,
   output logic [NUM_REGS-1:0]  onehot,
   output logic                 out_of_range
);

   always_comb begin
      onehot       = '0;
      out_of_range = (32'(sel) >= 32'(NUM_REGS));
      for (int i = 0; i < NUM_REGS; i++) begin
         onehot[i] = en && (32'(sel) == 32'(i));
      end
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM: accepts {opcode, rx, ry} over valid/ready, latches it,
// and sequences Moore register/ALU strobes, counting retired instructions.
module multicycle_control_unit
   import multicycle_control_unit_pkg::*;
#(
   parameter int NUM_REGS  = 16,
   parameter int REG_SEL_W = $clog2(NUM_REGS),
   parameter int OPCODE_W  = 4,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   multicycle_control_unit_if.slave bus,
   output logic                 done,
   output logic                 illegal,
   output logic                 busy,
   output logic [CNT_W-1:0]     retired_count
);

   localparam int IW = OPCODE_W + 2*REG_SEL_W;

   state_t                state, state_nxt;
   logic [IW-1:0]         ir;
   logic [OPCODE_W-1:0]   ir_op, live_op;
   logic [REG_SEL_W-1:0]  ir_rx, ir_ry, live_rx, live_ry, sel_rx, sel_ry;
   logic [NUM_REGS-1:0]   rx_hot, ry_hot;
   logic                  rx_oor, ry_oor, rx_en, ry_en, rin_en, rout_rx, bad;

   assign ir_op   = OPCODE_W'(instr_field(64'(ir), 2*REG_SEL_W, OPCODE_W));
   assign ir_rx   = REG_SEL_W'(instr_field(64'(ir), REG_SEL_W, REG_SEL_W));
   assign ir_ry   = REG_SEL_W'(instr_field(64'(ir), 0, REG_SEL_W));
   assign live_op = OPCODE_W'(instr_field(64'(bus.instr), 2*REG_SEL_W, OPCODE_W));
   assign live_rx = REG_SEL_W'(instr_field(64'(bus.instr), REG_SEL_W, REG_SEL_W));
   assign live_ry = REG_SEL_W'(instr_field(64'(bus.instr), 0, REG_SEL_W));

   // In IDLE the decoders only range-check the offered instruction; elsewhere they drive strobes from IR.
   assign sel_rx = (state == IDLE) ? live_rx : ir_rx;
   assign sel_ry = (state == IDLE) ? live_ry : ir_ry;

   reg_sel_decoder #(.NUM_REGS(NUM_REGS), .REG_SEL_W(REG_SEL_W)) u_rx_dec (
      .sel(sel_rx), .en(rx_en), .onehot(rx_hot), .out_of_range(rx_oor)
   );

   reg_sel_decoder #(.NUM_REGS(NUM_REGS), .REG_SEL_W(REG_SEL_W)) u_ry_dec (
      .sel(sel_ry), .en(ry_en), .onehot(ry_hot), .out_of_range(ry_oor)
   );

   always_comb begin
      bad = rx_oor;
      if (32'(live_op) > OP_NOP) bad = 1'b1;
      if (ry_oor && (32'(live_op) != OP_LOAD) && (32'(live_op) != OP_NOP)) bad = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         ir    <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && bus.instr_valid) ir <= bus.instr;
      end
   end

   always_comb begin
      state_nxt       = state;
      bus.instr_ready = 1'b0;
      bus.alu_mode    = ALU_ADD;
      bus.alu_a_in    = 1'b0;
      bus.alu_g_in    = 1'b0;
      bus.alu_g_out   = 1'b0;
      bus.ext_load    = 1'b0;
      done            = 1'b0;
      illegal         = 1'b0;
      rx_en           = 1'b0;
      ry_en           = 1'b0;
      rin_en          = 1'b0;
      rout_rx         = 1'b0;
      unique case (state)
         IDLE: begin
            bus.instr_ready = 1'b1;
            if (bus.instr_valid) begin
               if (bad) state_nxt = ERR;
               else begin
                  case (32'(live_op))
                     OP_LOAD: state_nxt = LOAD1;
                     OP_MOV:  state_nxt = MOVE;
                     OP_NOP:  state_nxt = NOPS;
                     default: state_nxt = ALU1;
                  endcase
               end
            end
         end
         LOAD1: if (bus.ext_data_valid) state_nxt = LOAD2;
         LOAD2: begin
            bus.ext_load = 1'b1;
            rx_en = 1'b1; rin_en = 1'b1; done = 1'b1;
            state_nxt = IDLE;
         end
         MOVE: begin
            rx_en = 1'b1; rin_en = 1'b1; ry_en = 1'b1; done = 1'b1;
            state_nxt = IDLE;
         end
         ALU1: begin
            rx_en = 1'b1; rout_rx = 1'b1; bus.alu_a_in = 1'b1;
            state_nxt = ALU2;
         end
         ALU2: begin
            ry_en = 1'b1; bus.alu_g_in = 1'b1;
            bus.alu_mode = alu_mode_of(32'(ir_op));
            state_nxt = ALU3;
         end
         ALU3: begin
            bus.alu_g_out = 1'b1;
            rx_en = 1'b1; rin_en = 1'b1; done = 1'b1;
            state_nxt = IDLE;
         end
         NOPS: begin
            done = 1'b1;
            state_nxt = IDLE;
         end
         ERR: begin
            illegal = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.rin  = rin_en ? rx_hot : '0;
   assign bus.rout = rout_rx ? rx_hot : ry_hot;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) retired_count <= '0;
      else if (done) retired_count <= retired_count + CNT_W'(1);
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: a 16-register unit for the main sequences and a 12-register,
// 4-bit-counter unit for register range errors and counter wrap.
module tb_multicycle_control_unit;

   logic        clk = 1'b0;
   logic        reset;
   int          compared = 0;
   int          mismatched = 0;
   int          exp_count16 = 0;

   logic        done16, illegal16, busy16;
   logic [15:0] count16;
   logic        done12, illegal12, busy12;
   logic [3:0]  count12;
   logic [7:0]  ctl16, ctl12;

   multicycle_control_unit_if #(.NUM_REGS(16), .REG_SEL_W(4), .OPCODE_W(4)) bus16 ();
   multicycle_control_unit_if #(.NUM_REGS(12), .REG_SEL_W(4), .OPCODE_W(4)) bus12 ();

   multicycle_control_unit #(.NUM_REGS(16), .REG_SEL_W(4), .OPCODE_W(4), .CNT_W(16)) dut16 (
      .clk(clk), .reset(reset), .bus(bus16),
      .done(done16), .illegal(illegal16), .busy(busy16), .retired_count(count16)
   );

   multicycle_control_unit #(.NUM_REGS(12), .REG_SEL_W(4), .OPCODE_W(4), .CNT_W(4)) dut12 (
      .clk(clk), .reset(reset), .bus(bus12),
      .done(done12), .illegal(illegal12), .busy(busy12), .retired_count(count12)
   );

   always #5 clk = ~clk;

   // Control bits packed as {ready, a_in, g_in, g_out, ext_load, done, illegal, busy}.
   assign ctl16 = {bus16.instr_ready, bus16.alu_a_in, bus16.alu_g_in, bus16.alu_g_out,
                   bus16.ext_load, done16, illegal16, busy16};
   assign ctl12 = {bus12.instr_ready, bus12.alu_a_in, bus12.alu_g_in, bus12.alu_g_out,
                   bus12.ext_load, done12, illegal12, busy12};

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check16(input string tag, input logic [15:0] e_rin, input logic [15:0] e_rout,
                          input logic [2:0] e_mode, input logic [7:0] e_ctl);
      checkOutput({tag, ".rin"},  64'(bus16.rin),      64'(e_rin));
      checkOutput({tag, ".rout"}, 64'(bus16.rout),     64'(e_rout));
      checkOutput({tag, ".mode"}, 64'(bus16.alu_mode), 64'(e_mode));
      checkOutput({tag, ".ctl"},  64'(ctl16),          64'(e_ctl));
   endtask

   task automatic check12(input string tag, input logic [11:0] e_rin, input logic [11:0] e_rout,
                          input logic [7:0] e_ctl);
      checkOutput({tag, ".rin"},  64'(bus12.rin),  64'(e_rin));
      checkOutput({tag, ".rout"}, 64'(bus12.rout), 64'(e_rout));
      checkOutput({tag, ".ctl"},  64'(ctl12),      64'(e_ctl));
   endtask

   // Called at a negedge in IDLE; returns at the negedge of the first cycle after accept.
   task automatic applyStimulus(input bit to12, input logic [3:0] op, input logic [3:0] rx,
                                input logic [3:0] ry);
      if (to12) begin
         bus12.instr = {op, rx, ry};
         bus12.instr_valid = 1'b1;
      end else begin
         bus16.instr = {op, rx, ry};
         bus16.instr_valid = 1'b1;
      end
      @(negedge clk);
      bus12.instr_valid = 1'b0;
      bus16.instr_valid = 1'b0;
   endtask

   task automatic runAlu16(input string tag, input logic [3:0] op, input logic [3:0] rx,
                           input logic [3:0] ry, input logic [2:0] e_mode);
      applyStimulus(1'b0, op, rx, ry);
      check16({tag, ".c1"}, 16'h0000, 16'h0001 << rx, 3'b000, 8'h41);
      @(negedge clk);
      check16({tag, ".c2"}, 16'h0000, 16'h0001 << ry, e_mode, 8'h21);
      @(negedge clk);
      check16({tag, ".c3"}, 16'h0001 << rx, 16'h0000, 3'b000, 8'h15);
      exp_count16++;
      @(negedge clk);
      check16({tag, ".idle"}, 16'h0000, 16'h0000, 3'b000, 8'h80);
      checkOutput({tag, ".count"}, 64'(count16), 64'(exp_count16));
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1;
      bus16.instr_valid = 1'b0; bus16.instr = '0; bus16.ext_data_valid = 1'b0;
      bus12.instr_valid = 1'b0; bus12.instr = '0; bus12.ext_data_valid = 1'b0;
      @(negedge clk);
      check16("rst", 16'h0000, 16'h0000, 3'b000, 8'h80);
      checkOutput("rst.count", 64'(count16), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      check16("idle0", 16'h0000, 16'h0000, 3'b000, 8'h80);

      runAlu16("add", 4'd2, 4'd3, 4'd5, 3'b000);

      // LOAD r15 with external data absent for three LOAD1 cycles
      applyStimulus(1'b0, 4'd0, 4'd15, 4'd0);
      for (int i = 0; i < 4; i++) begin
         check16($sformatf("load1.%0d", i), 16'h0000, 16'h0000, 3'b000, 8'h01);
         if (i == 3) bus16.ext_data_valid = 1'b1;
         @(negedge clk);
      end
      check16("load2", 16'h8000, 16'h0000, 3'b000, 8'h0D);
      bus16.ext_data_valid = 1'b0;
      exp_count16++;
      @(negedge clk);
      checkOutput("load.count", 64'(count16), 64'(exp_count16));

      applyStimulus(1'b0, 4'd1, 4'd2, 4'd2);
      check16("mov", 16'h0004, 16'h0004, 3'b000, 8'h05);
      exp_count16++;
      @(negedge clk);
      check16("mov.idle", 16'h0000, 16'h0000, 3'b000, 8'h80);
      checkOutput("mov.count", 64'(count16), 64'(exp_count16));

      runAlu16("sub", 4'd3, 4'd1, 4'd7, 3'b001);
      runAlu16("xor", 4'd4, 4'd0, 4'd15, 3'b010);
      runAlu16("and", 4'd5, 4'd14, 4'd9, 3'b011);
      runAlu16("or",  4'd6, 4'd6, 4'd6, 3'b100);

      applyStimulus(1'b0, 4'd9, 4'd1, 4'd1);
      check16("op9", 16'h0000, 16'h0000, 3'b000, 8'h03);
      @(negedge clk);
      check16("op9.idle", 16'h0000, 16'h0000, 3'b000, 8'h80);
      checkOutput("op9.count", 64'(count16), 64'(exp_count16));

      // Asynchronous reset in ALU2 of an XOR
      applyStimulus(1'b0, 4'd4, 4'd1, 4'd2);
      @(negedge clk);
      check16("xr.alu2", 16'h0000, 16'h0004, 3'b010, 8'h21);
      #1 reset = 1'b1;
      #1 check16("xr.async", 16'h0000, 16'h0000, 3'b000, 8'h80);
      checkOutput("xr.count", 64'(count16), 64'd0);
      #1 reset = 1'b0;
      exp_count16 = 0;
      @(negedge clk);
      check16("xr.after", 16'h0000, 16'h0000, 3'b000, 8'h80);
      applyStimulus(1'b0, 4'd7, 4'd0, 4'd0);
      check16("nop", 16'h0000, 16'h0000, 3'b000, 8'h05);
      exp_count16++;
      @(negedge clk);
      checkOutput("nop.count", 64'(count16), 64'(exp_count16));

      // 12-register unit: range errors, ry ignored for LOAD, 4-bit counter wrap
      check12("r12.idle", 12'h000, 12'h000, 8'h80);
      applyStimulus(1'b1, 4'd2, 4'd3, 4'd13);
      check12("r12.addry13", 12'h000, 12'h000, 8'h03);
      @(negedge clk);
      applyStimulus(1'b1, 4'd1, 4'd12, 4'd0);
      check12("r12.movrx12", 12'h000, 12'h000, 8'h03);
      @(negedge clk);
      checkOutput("r12.errcount", 64'(count12), 64'd0);
      bus12.ext_data_valid = 1'b1;
      applyStimulus(1'b1, 4'd0, 4'd2, 4'd13);
      check12("r12.load1", 12'h000, 12'h000, 8'h01);
      @(negedge clk);
      check12("r12.load2", 12'h004, 12'h000, 8'h0D);
      bus12.ext_data_valid = 1'b0;
      @(negedge clk);
      checkOutput("r12.loadcount", 64'(count12), 64'd1);
      for (int i = 0; i < 14; i++) begin
         applyStimulus(1'b1, 4'd7, 4'd0, 4'd0);
         @(negedge clk);
      end
      checkOutput("r12.count15", 64'(count12), 64'hF);
      applyStimulus(1'b1, 4'd7, 4'd11, 4'd0);
      check12("r12.nopdone", 12'h000, 12'h000, 8'h05);
      @(negedge clk);
      checkOutput("r12.wrap", 64'(count12), 64'd0);
      check12("r12.final", 12'h000, 12'h000, 8'h80);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
